// File: rtl/sifive_tlul_pkg.sv
// Shared TileLink-UL opcode and response types for the scratch/mailbox memory responder.
package sifive_tlul_pkg;

   localparam int TL_DATA_W = 32;
   localparam int TL_MASK_W = 4;

   typedef enum logic [2:0] {
      PUT_FULL    = 3'd0,
      PUT_PARTIAL = 3'd1,
      GET         = 3'd4
   } tl_a_opcode_e;

   typedef enum logic [2:0] {
      ACK      = 3'd0,
      ACK_DATA = 3'd1
   } tl_d_opcode_e;

   // Width-independent D fields; size and source are sized by the link parameters.
   typedef struct packed {
      tl_d_opcode_e         opcode;
      logic                 denied;
      logic                 corrupt;
      logic [TL_DATA_W-1:0] data;
   } tl_d_rsp_t;

   function automatic logic is_put(input logic [2:0] op);
      return (op == PUT_FULL) || (op == PUT_PARTIAL);
   endfunction

endpackage

// File: rtl/sifive_tlul_mem_responder_if.sv
// TileLink-UL A/D channel bundle; master = requester side, slave = responder side.
interface sifive_tlul_mem_responder_if #(
   parameter int ADDR_W = 30,
   parameter int SRC_W  = 7,
   parameter int SIZE_W = 3
);
   import sifive_tlul_pkg::*;

   logic                 a_valid;
   logic                 a_ready;
   logic [2:0]           a_opcode;
   logic [2:0]           a_param;
   logic [SIZE_W-1:0]    a_size;
   logic [SRC_W-1:0]     a_source;
   logic [ADDR_W-1:0]    a_address;
   logic [TL_MASK_W-1:0] a_mask;
   logic [TL_DATA_W-1:0] a_data;

   logic                 d_valid;
   logic                 d_ready;
   logic [2:0]           d_opcode;
   logic [1:0]           d_param;
   logic [SIZE_W-1:0]    d_size;
   logic [SRC_W-1:0]     d_source;
   logic                 d_denied;
   logic [TL_DATA_W-1:0] d_data;
   logic                 d_corrupt;

   modport master (
      output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
      input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt
   );

   modport slave (
      input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
      output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt
   );

endinterface

// File: rtl/sifive_tlul_bytemask_ram.sv
// DEPTH x 32 flop array with byte-enable write and asynchronous read that bypasses a same-cycle write.
module sifive_tlul_bytemask_ram
   import sifive_tlul_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic                 i_clk,
   input  logic                 i_we,
   input  logic [IDX_W-1:0]     i_waddr,
   input  logic [TL_MASK_W-1:0] i_wmask,
   input  logic [TL_DATA_W-1:0] i_wdata,
   input  logic [IDX_W-1:0]     i_raddr,
   output logic [TL_DATA_W-1:0] o_rdata
);

   logic [TL_DATA_W-1:0] r_mem [DEPTH];
   logic [TL_DATA_W-1:0] w_merged;

   // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
   always_comb begin
      w_merged = r_mem[i_waddr];
      for (int i = 0; i < TL_MASK_W; i++) begin
         if (i_wmask[i]) w_merged[8*i +: 8] = i_wdata[8*i +: 8];
      end
   end

   // NOTE: storage is deliberately left out of reset; contents are undefined after reset.
   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= w_merged;
   end

   assign o_rdata = (i_we && (i_waddr == i_raddr)) ? w_merged : r_mem[i_raddr];

endmodule

// File: rtl/sifive_tlul_mem_responder.sv
// TL-UL manager: decodes A, services it from the byte-mask RAM, returns one registered D beat.
// Optional SIFIVE_TLUL_RESP_ERROR_EN: denied responses for out-of-window, oversize or illegal requests.
module sifive_tlul_mem_responder
   import sifive_tlul_pkg::*;
#(
   parameter int                ADDR_W    = 30,
   parameter int                SRC_W     = 7,
   parameter int                SIZE_W    = 3,
   parameter int                DEPTH     = 64,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input logic                        clock,
   input logic                        reset,
   sifive_tlul_mem_responder_if.slave tl
);

   localparam int IDX_W = $clog2(DEPTH);

   logic [ADDR_W-1:0]    w_offset;
   logic [IDX_W-1:0]     w_index;
   logic                 w_in_window;
   logic                 w_a_fire;
   logic                 w_d_fire;
   logic                 w_is_put;
   logic                 w_is_get;
   logic                 w_err;
   logic                 w_we;
   logic [TL_DATA_W-1:0] w_rdata;
   tl_d_rsp_t            w_rsp;
   logic                 w_unused;

   logic                 r_d_valid;
   tl_d_rsp_t            r_rsp;
   logic [SIZE_W-1:0]    r_size;
   logic [SRC_W-1:0]     r_source;

   assign w_offset    = tl.a_address - BASE_ADDR;
   assign w_index     = w_offset[2 +: IDX_W];
   assign w_in_window = (w_offset >> (IDX_W + 2)) == '0;

   assign tl.a_ready = ~r_d_valid | tl.d_ready;
   assign w_a_fire   = tl.a_valid & tl.a_ready;
   assign w_d_fire   = r_d_valid & tl.d_ready;
   assign w_is_put   = is_put(tl.a_opcode);

`ifdef SIFIVE_TLUL_RESP_ERROR_EN
   assign w_is_get = (tl.a_opcode == GET);
   assign w_err    = ~w_in_window | (tl.a_size > SIZE_W'(2)) | ~(w_is_put | w_is_get);
`else
   // Illegal opcodes fall through as Get; out-of-window addresses wrap on the index.
   assign w_is_get = ~w_is_put;
   assign w_err    = 1'b0;
`endif

   // A write landing on the reset-asserted edge must not complete.
   assign w_we = w_a_fire & w_is_put & ~w_err & ~reset;

   sifive_tlul_bytemask_ram #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_ram (
      .i_clk   (clock),
      .i_we    (w_we),
      .i_waddr (w_index),
      .i_wmask (tl.a_mask),
      .i_wdata (tl.a_data),
      .i_raddr (w_index),
      .o_rdata (w_rdata)
   );

   always_comb begin
      w_rsp         = '0;
      w_rsp.opcode  = w_is_get ? ACK_DATA : ACK;
      w_rsp.denied  = w_err;
      w_rsp.corrupt = w_err & w_is_get;
      w_rsp.data    = (w_is_get & ~w_err) ? w_rdata : '0;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_d_valid <= 1'b0;
         r_rsp     <= '0;
         r_size    <= '0;
         r_source  <= '0;
      end else if (w_a_fire) begin
         r_d_valid <= 1'b1;
         r_rsp     <= w_rsp;
         r_size    <= tl.a_size;
         r_source  <= tl.a_source;
      end else if (w_d_fire) begin
         r_d_valid <= 1'b0;
      end
   end

   assign tl.d_valid   = r_d_valid;
   assign tl.d_opcode  = r_rsp.opcode;
   assign tl.d_param   = '0;
   assign tl.d_size    = r_size;
   assign tl.d_source  = r_source;
   assign tl.d_denied  = r_rsp.denied;
   assign tl.d_data    = r_rsp.data;
   assign tl.d_corrupt = r_rsp.corrupt;

   assign w_unused = ^{tl.a_param, w_offset, w_in_window};

endmodule

// File: tb/tb_sifive_tlul_mem_responder.sv
// Directed vector bench for sifive_tlul_mem_responder plus back-pressure, streaming and reset sequences.
module tb_sifive_tlul_mem_responder;
   import sifive_tlul_pkg::*;

   typedef struct {
      logic [2:0]  op;
      logic [2:0]  size;
      logic [29:0] addr;
      logic [3:0]  mask;
      logic [31:0] data;
      logic [6:0]  src;
      logic [2:0]  e_op;
      logic [31:0] e_data;
      logic        e_denied;
   } vec_t;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   vec_t vecs [13];

   sifive_tlul_mem_responder_if #(.ADDR_W(30), .SRC_W(7), .SIZE_W(3)) tl ();

   sifive_tlul_mem_responder #(
      .ADDR_W    (30),
      .SRC_W     (7),
      .SIZE_W    (3),
      .DEPTH     (64),
      .BASE_ADDR (30'h0)
   ) dut (
      .clock (clk),
      .reset (rst),
      .tl    (tl)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive_a(input logic [2:0] op, input logic [2:0] size, input logic [29:0] addr,
                          input logic [3:0] mask, input logic [31:0] data, input logic [6:0] src);
      tl.a_valid   = 1'b1;
      tl.a_opcode  = op;
      tl.a_size    = size;
      tl.a_address = addr;
      tl.a_mask    = mask;
      tl.a_data    = data;
      tl.a_source  = src;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;

      vecs[0]  = '{PUT_FULL,    3'd2, 30'h10,  4'hF, 32'hDEADBEEF, 7'd5,  ACK,      32'h0,        1'b0};
      vecs[1]  = '{GET,         3'd2, 30'h10,  4'hF, 32'h0,        7'd6,  ACK_DATA, 32'hDEADBEEF, 1'b0};
      vecs[2]  = '{PUT_PARTIAL, 3'd0, 30'h11,  4'h2, 32'h00AA5500, 7'd1,  ACK,      32'h0,        1'b0};
      vecs[3]  = '{GET,         3'd2, 30'h10,  4'hF, 32'h0,        7'd2,  ACK_DATA, 32'hDEAD55EF, 1'b0};
      vecs[4]  = '{PUT_FULL,    3'd2, 30'h0,   4'hF, 32'h12345678, 7'd3,  ACK,      32'h0,        1'b0};
      vecs[5]  = '{PUT_PARTIAL, 3'd2, 30'h0,   4'h0, 32'hFFFFFFFF, 7'd4,  ACK,      32'h0,        1'b0};
      vecs[6]  = '{GET,         3'd2, 30'h0,   4'hF, 32'h0,        7'd7,  ACK_DATA, 32'h12345678, 1'b0};
      vecs[7]  = '{PUT_PARTIAL, 3'd2, 30'h0,   4'h9, 32'hAABBCCDD, 7'd8,  ACK,      32'h0,        1'b0};
      vecs[8]  = '{GET,         3'd1, 30'h2,   4'hF, 32'h0,        7'd9,  ACK_DATA, 32'hAA3456DD, 1'b0};
      vecs[9]  = '{PUT_FULL,    3'd2, 30'hFC,  4'hF, 32'hCAFEF00D, 7'd10, ACK,      32'h0,        1'b0};
      vecs[10] = '{GET,         3'd2, 30'hFC,  4'hF, 32'h0,        7'd11, ACK_DATA, 32'hCAFEF00D, 1'b0};
`ifdef SIFIVE_TLUL_RESP_ERROR_EN
      vecs[11] = '{GET,         3'd2, 30'h100, 4'hF, 32'h0,        7'd12, ACK_DATA, 32'h0,        1'b1};
`else
      vecs[11] = '{GET,         3'd2, 30'h100, 4'hF, 32'h0,        7'd12, ACK_DATA, 32'hAA3456DD, 1'b0};
`endif
      vecs[12] = '{GET,         3'd0, 30'h11,  4'hF, 32'h0,        7'd13, ACK_DATA, 32'hDEAD55EF, 1'b0};

      rst         = 1'b0;
      tl.a_valid  = 1'b0;
      tl.a_param  = 3'd0;
      tl.d_ready  = 1'b1;
      drive_a(GET, 3'd2, 30'h0, 4'hF, 32'h0, 7'd0);
      tl.a_valid  = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("reset d_valid", tl.d_valid, 0);
      check("reset a_ready", tl.a_ready, 1);
      check("reset d_opcode", tl.d_opcode, 0);
      check("reset d_data", tl.d_data, 0);
      check("reset d_source", tl.d_source, 0);
      check("reset d_denied", tl.d_denied, 0);
      check("reset d_corrupt", tl.d_corrupt, 0);
      check("reset d_param", tl.d_param, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;

      // Table: one request per vector, d_ready high so D and the next A fire together.
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         drive_a(vecs[i].op, vecs[i].size, vecs[i].addr, vecs[i].mask, vecs[i].data, vecs[i].src);
         @(posedge clk);
         #1 tl.a_valid = 1'b0;
         check($sformatf("vec%0d d_valid", i), tl.d_valid, 1);
         check($sformatf("vec%0d d_opcode", i), tl.d_opcode, vecs[i].e_op);
         check($sformatf("vec%0d d_data", i), tl.d_data, vecs[i].e_data);
         check($sformatf("vec%0d d_source", i), tl.d_source, vecs[i].src);
         check($sformatf("vec%0d d_size", i), tl.d_size, vecs[i].size);
         check($sformatf("vec%0d d_denied", i), tl.d_denied, vecs[i].e_denied);
         check($sformatf("vec%0d d_corrupt", i), tl.d_corrupt,
               {31'd0, vecs[i].e_denied & (vecs[i].e_op == ACK_DATA)});
      end

      // Put at edge N then Get at edge N+1 to the same word.
      @(negedge clk);
      drive_a(PUT_FULL, 3'd2, 30'h20, 4'hF, 32'h0BADCAFE, 7'd40);
      @(posedge clk);
      #1 check("wf put d_opcode", tl.d_opcode, ACK);
      check("wf put d_source", tl.d_source, 40);
      @(negedge clk);
      drive_a(GET, 3'd2, 30'h20, 4'hF, 32'h0, 7'd41);
      @(posedge clk);
      #1 tl.a_valid = 1'b0;
      check("wf get d_data", tl.d_data, 32'h0BADCAFE);
      check("wf get d_source", tl.d_source, 41);
      @(posedge clk);
      #1 check("wf drained d_valid", tl.d_valid, 0);

      // Back-pressure: response must hold for 5 stalled cycles, then drain once.
      @(negedge clk);
      tl.d_ready = 1'b0;
      drive_a(GET, 3'd2, 30'h10, 4'hF, 32'h0, 7'd20);
      @(posedge clk);
      #1 tl.a_valid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         check($sformatf("stall%0d a_ready", c), tl.a_ready, 0);
         check($sformatf("stall%0d d_valid", c), tl.d_valid, 1);
         check($sformatf("stall%0d d_data", c), tl.d_data, 32'hDEAD55EF);
         check($sformatf("stall%0d d_source", c), tl.d_source, 20);
      end
      @(negedge clk);
      tl.d_ready = 1'b1;
      #1 check("release a_ready", tl.a_ready, 1);
      @(posedge clk);
      #1 check("release d_valid", tl.d_valid, 0);

      // Streaming: eight Gets on consecutive cycles.
      for (int s = 0; s < 8; s++) begin
         @(negedge clk);
         check($sformatf("stream%0d a_ready", s), tl.a_ready, 1);
         drive_a(GET, 3'd2, 30'h10, 4'hF, 32'h0, 7'(30 + s));
         @(posedge clk);
         #1;
         check($sformatf("stream%0d d_valid", s), tl.d_valid, 1);
         check($sformatf("stream%0d d_source", s), tl.d_source, 30 + s);
         check($sformatf("stream%0d d_data", s), tl.d_data, 32'hDEAD55EF);
      end
      tl.a_valid = 1'b0;
      @(posedge clk);
      #1 check("stream drained d_valid", tl.d_valid, 0);

      // Reset while a response is pending, with a write offered during reset.
      @(negedge clk);
      tl.d_ready = 1'b0;
      drive_a(GET, 3'd2, 30'h10, 4'hF, 32'h0, 7'd50);
      @(posedge clk);
      #1 tl.a_valid = 1'b0;
      check("pre-reset d_valid", tl.d_valid, 1);
      #2 rst = 1'b1;
      #1;
      check("mid-reset d_valid", tl.d_valid, 0);
      check("mid-reset d_source", tl.d_source, 0);
      check("mid-reset a_ready", tl.a_ready, 1);
      drive_a(PUT_FULL, 3'd2, 30'h10, 4'hF, 32'h0, 7'd51);
      @(posedge clk);
      @(negedge clk);
      tl.a_valid = 1'b0;
      rst        = 1'b0;
      tl.d_ready = 1'b1;
      #1 check("post-reset d_valid", tl.d_valid, 0);
      @(negedge clk);
      drive_a(GET, 3'd2, 30'h10, 4'hF, 32'h0, 7'd52);
      @(posedge clk);
      #1 tl.a_valid = 1'b0;
      check("post-reset get d_valid", tl.d_valid, 1);
      check("post-reset get d_data", tl.d_data, 32'hDEAD55EF);
      check("post-reset get d_source", tl.d_source, 52);
      @(posedge clk);
      #1 check("post-reset drained d_valid", tl.d_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
